// File: rtl/fetch_queue_splitter_pkg.sv
// fetch_pkg: MIPS instruction field positions and fetch queue widths.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM16_HI = 15;
  localparam int IMM16_LO = 0;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;
endpackage

// File: rtl/fetch_queue_splitter_if.sv
// fetch_queue_splitter_if: fetch-side push and decode-side head/field signals.
interface fetch_queue_splitter_if
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [INSTR_W-1:0] in_instr, out_instr, imm32_sext, imm32_zext;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [PTR_W:0] count;
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input in_ready, out_valid, out_pc, out_instr, opcode, rs, rt, rd, shamt, funct,
          imm16, imm26, imm32_sext, imm32_zext, count
  );
  modport slave (
    input in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, opcode, rs, rt, rd, shamt, funct,
           imm16, imm26, imm32_sext, imm32_zext, count
  );
endinterface

// File: rtl/fetch_queue_splitter_instr_field_split.sv
// instr_field_split: combinational MIPS word to field and immediate decode.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [5:0]         opcode_o,
  output logic [4:0]         rs_o,
  output logic [4:0]         rt_o,
  output logic [4:0]         rd_o,
  output logic [4:0]         shamt_o,
  output logic [5:0]         funct_o,
  output logic [15:0]        imm16_o,
  output logic [25:0]        imm26_o,
  output logic [31:0]        imm32_sext_o,
  output logic [31:0]        imm32_zext_o
);
  always_comb begin
    opcode_o = instr_i[OPCODE_HI:OPCODE_LO];
    rs_o = instr_i[RS_HI:RS_LO];
    rt_o = instr_i[RT_HI:RT_LO];
    rd_o = instr_i[RD_HI:RD_LO];
    shamt_o = instr_i[SHAMT_HI:SHAMT_LO];
    funct_o = instr_i[FUNCT_HI:FUNCT_LO];
    imm16_o = instr_i[IMM16_HI:IMM16_LO];
    imm26_o = instr_i[IMM26_HI:IMM26_LO];
    imm32_sext_o = {{16{instr_i[IMM16_HI]}}, instr_i[IMM16_HI:IMM16_LO]};
    imm32_zext_o = {16'h0, instr_i[IMM16_HI:IMM16_LO]};
  end
endmodule

// File: rtl/fetch_queue_splitter.sv
// fetch_queue_splitter: circular fetch queue presenting a pre-decoded head entry.
module fetch_queue_splitter
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  fetch_queue_splitter_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW = PTR_W + 1;
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push, pop;
  // Handshakes come from the registered count only, so no out_ready->in_ready path.
  always_comb begin
    q.in_ready = cnt_q != CW'(DEPTH);
    q.out_valid = cnt_q != '0;
    push = q.in_valid & q.in_ready;
    pop = q.out_valid & q.out_ready;
    wr_d = flush ? '0 : wr_q + PTR_W'(push);
    rd_d = flush ? '0 : rd_q + PTR_W'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    q.out_pc = q.out_valid ? pc_mem[rd_q] : '0;
    q.out_instr = q.out_valid ? instr_mem[rd_q] : NOP_INSTR;
    q.count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      pc_mem[wr_q] <= q.in_pc;
      instr_mem[wr_q] <= q.in_instr;
    end
  end
  instr_field_split u_split (
    .instr_i      (q.out_instr),
    .opcode_o     (q.opcode),
    .rs_o         (q.rs),
    .rt_o         (q.rt),
    .rd_o         (q.rd),
    .shamt_o      (q.shamt),
    .funct_o      (q.funct),
    .imm16_o      (q.imm16),
    .imm26_o      (q.imm26),
    .imm32_sext_o (q.imm32_sext),
    .imm32_zext_o (q.imm32_zext)
  );
endmodule
